// File: rtl/accel_avg_filter_if.sv
// accel_avg_filter_if
//   Bundles the sample input and the averaged-result handshake of the
//   accelerometer averaging filter.
//   slave  : filter side (consumes up_*, produces down_*, overrun_cnt)
//   master : producer/consumer side (drives up_*, down_ready)
//   Signals:
//     up_valid          one-cycle pulse, new x/y/z sample present
//     up_x/up_y/up_z    signed axis samples
//     down_valid        averaged triple available
//     down_ready        consumer accepts triple when down_valid & down_ready
//     down_x/y/z        signed averaged axis values
//     overrun_cnt       saturating count of results overwritten unread
interface accel_avg_filter_if #(
    parameter int WIDTH = 16
);
    logic                    up_valid;
    logic signed [WIDTH-1:0] up_x;
    logic signed [WIDTH-1:0] up_y;
    logic signed [WIDTH-1:0] up_z;
    logic                    down_valid;
    logic                    down_ready;
    logic signed [WIDTH-1:0] down_x;
    logic signed [WIDTH-1:0] down_y;
    logic signed [WIDTH-1:0] down_z;
    logic [7:0]              overrun_cnt;

    modport slave (
        input  up_valid, up_x, up_y, up_z, down_ready,
        output down_valid, down_x, down_y, down_z, overrun_cnt
    );

    modport master (
        output up_valid, up_x, up_y, up_z, down_ready,
        input  down_valid, down_x, down_y, down_z, overrun_cnt
    );
endinterface

// File: rtl/accel_avg_filter.sv
// accel_avg_filter
//   Block-averages 3-axis signed samples over windows of N = 2**LOG2_N
//   samples. Each completed window presents floor(sum / N) per axis on a
//   registered valid/ready output; a result replaced before it was consumed
//   bumps a saturating overrun counter.
//   Ports:
//     clk   single clock, rising edge
//     rstn  asynchronous active-low reset
//     bus   accel_avg_filter_if.slave (sample input, result output, overrun_cnt)
module accel_avg_filter #(
    parameter int WIDTH  = 16,
    parameter int LOG2_N = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    accel_avg_filter_if.slave    bus
);
    localparam int AW = WIDTH + LOG2_N;
    // Keep a 1-bit counter when N = 1; it then simply stays at 0.
    localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
    localparam int N  = 1 << LOG2_N;

    logic [CW-1:0]           cnt;
    logic signed [AW-1:0]    acc  [3];
    logic signed [WIDTH-1:0] smp  [3];
    logic signed [AW-1:0]    sum  [3];
    logic signed [WIDTH-1:0] avg  [3];
    logic signed [WIDTH-1:0] dout [3];
    logic                    dv;
    logic [7:0]              ovr;
    logic                    win_done;

    assign smp[0] = bus.up_x;
    assign smp[1] = bus.up_y;
    assign smp[2] = bus.up_z;

    // The accumulator is wide enough for N full-scale samples, so the
    // arithmetic shift always lands back inside WIDTH bits.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sum[i] = acc[i] + AW'(smp[i]);
            avg[i] = WIDTH'(sum[i] >>> LOG2_N);
        end
    end

    assign win_done = bus.up_valid && (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            dv  <= 1'b0;
            ovr <= '0;
            for (int i = 0; i < 3; i++) begin
                acc[i]  <= '0;
                dout[i] <= '0;
            end
        end else begin
            if (bus.up_valid) begin
                if (win_done) begin
                    cnt <= '0;
                    for (int i = 0; i < 3; i++) begin
                        acc[i]  <= '0;
                        dout[i] <= avg[i];
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                    for (int i = 0; i < 3; i++) begin
                        acc[i] <= sum[i];
                    end
                end
            end

            if (win_done) begin
                dv <= 1'b1;
                // Only an unread result being replaced counts as an overrun.
                if (dv && !bus.down_ready && (ovr != 8'hFF)) begin
                    ovr <= ovr + 8'd1;
                end
            end else if (dv && bus.down_ready) begin
                dv <= 1'b0;
            end
        end
    end

    assign bus.down_valid  = dv;
    assign bus.down_x      = dout[0];
    assign bus.down_y      = dout[1];
    assign bus.down_z      = dout[2];
    assign bus.overrun_cnt = ovr;
endmodule

// File: doc/accel_avg_filter.md
ACCEL_AVG_FILTER -- requirements
Module: accel_avg_filter

Interface
REQ-001 Parameter WIDTH, default 16: width of each signed two's-complement axis sample.
REQ-002 Parameter LOG2_N, default 2: log2 of the samples per averaging window (N = 2**LOG2_N), legal range 0..4.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 up_valid  input  1  one-cycle pulse: new x/y/z sample present (no upstream backpressure).
REQ-006 up_x, up_y, up_z  input  WIDTH each  signed axis samples, sampled when up_valid=1.
REQ-007 down_valid  output  1  averaged triple available.
REQ-008 down_ready  input  1  consumer accepts triple when down_valid & down_ready.
REQ-009 down_x, down_y, down_z  output  WIDTH each  signed averaged axis values.
REQ-010 overrun_cnt  output  8  saturating count of averaged results overwritten before consumption.

Function
REQ-011 Three signed accumulators of WIDTH+LOG2_N bits and a LOG2_N-bit sample counter shall form the window state.
REQ-012 Each up_valid cycle shall add the sign-extended samples to the accumulators and increment the sample counter.
REQ-013 On the up_valid that brings the count to N (counter wraps to 0), the window shall complete: outputs load (acc + sample) arithmetically shifted right by LOG2_N, accumulators clear to 0 in the same edge.
REQ-014 Rounding shall be truncation toward negative infinity (arithmetic shift); the result always fits WIDTH bits, no saturation logic required.
REQ-015 Latency: down_valid shall assert on the rising edge that samples the Nth up_valid (visible the following cycle); no further pipeline stages.
REQ-016 down_x/y/z shall be registered and held stable while down_valid=1 and down_ready=0, unless overwritten per REQ-018.
REQ-017 Handshake: down_valid & down_ready in a cycle with no window completion shall clear down_valid next cycle; outputs retain last value.
REQ-018 Window completion while down_valid=1 and down_ready=0: new triple overwrites, down_valid stays 1, overrun_cnt increments, saturating at 255.
REQ-019 Window completion while down_valid=1 and down_ready=1: old triple consumed, new triple loaded, down_valid stays 1, overrun_cnt unchanged.
REQ-020 up_valid shall be accepted in every cycle regardless of down_ready; back-to-back up_valid pulses are legal.
REQ-021 With LOG2_N=0, every up_valid shall produce an output equal to the input sample, same latency.
REQ-022 down_valid shall not assert combinationally from any input.

Reset
REQ-023 rstn low shall asynchronously clear accumulators, sample counter, down_valid, down_x/y/z and overrun_cnt to 0.
REQ-024 Reset mid-window shall discard the partial window; first output after release shall average exactly the next N samples.
REQ-025 Deassertion of rstn shall be treated as synchronous to clk by the integrator; block requires no reset-release handling.

Verification
REQ-026 N=4, x samples 1,2,3,4 (y,z = 0), down_ready=1 -> down_x=2, down_y=0, down_z=0, down_valid high exactly one cycle after the 4th up_valid, for one cycle.
REQ-027 N=4, x samples -1,-1,-1,-2 -> down_x=-2 (0xFFFE); x four times 0x7FFF -> 0x7FFF; four times 0x8000 -> 0x8000.
REQ-028 N=4, down_ready=0, 12 samples (three windows of constants 10, 20, 30) -> down_valid stays 1, down_x=30, overrun_cnt=2; then down_ready=1 one cycle -> down_valid 0 next cycle.
REQ-029 Window completion coinciding with down_ready=1 while holding 5 -> new value presented next cycle, down_valid continuous, overrun_cnt unchanged.
REQ-030 Two samples into a window, pulse rstn low 1 cycle mid-cycle -> outputs 0 immediately; next 4 samples of 8 -> down_x=8 (no stale contribution).
REQ-031 300 forced overruns -> overrun_cnt=255, no wrap.
